// File: rtl/avalon_st_sink_fifo_pkg.sv
// rtl/avalon_st_sink_fifo_pkg.sv - shared framing FSM encodings and helpers
package avalon_st_sink_fifo_pkg;

  typedef enum logic {
    ST_SEEK  = 1'b0,
    ST_FRAME = 1'b1
  } frame_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/avalon_st_sink_fifo_if.sv
// rtl/avalon_st_sink_fifo_if.sv - sink-side and IP-side beat streams of the sink FIFO
interface avalon_st_sink_fifo_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  snk_valid;
  logic                  snk_ready;
  logic [DATA_WIDTH-1:0] snk_data;
  logic                  snk_sop;
  logic                  snk_eop;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_sop;
  logic                  out_eop;

  modport slave (
    input  snk_valid, snk_data, snk_sop, snk_eop, out_ready,
    output snk_ready, out_valid, out_data, out_sop, out_eop
  );

  modport master (
    output snk_valid, snk_data, snk_sop, snk_eop, out_ready,
    input  snk_ready, out_valid, out_data, out_sop, out_eop
  );
endinterface

// File: rtl/avalon_st_fifo_mem.sv
// rtl/avalon_st_fifo_mem.sv - DEPTH-entry register FIFO with wrapping pointers and explicit level
module avalon_st_fifo_mem #(
  parameter int DW    = 18,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_en,
  input  logic [DW-1:0]    i_wr_data,
  input  logic             i_rd_en,
  output logic [DW-1:0]    o_rd_data,
  output logic [LVL_W-1:0] o_level
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  // Pointers are exactly log2(DEPTH) wide so they wrap for free; level disambiguates full/empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_wr_en) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (i_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({i_wr_en, i_rd_en})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_level   = r_level;
endmodule

// File: rtl/avalon_st_sink_fifo.sv
// rtl/avalon_st_sink_fifo.sv - Avalon-ST sink front end: buffering, backpressure, frame checking
module avalon_st_sink_fifo
  import avalon_st_sink_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 4,
  parameter int FRAME_BEATS = 0,
  parameter int CNT_WIDTH   = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  avalon_st_sink_fifo_if.slave     bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     frame_err,
  output logic [15:0]              err_count
);
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int DW    = DATA_WIDTH + 2;
  localparam logic [LVL_W-1:0]   FULL_LVL  = LVL_W'(DEPTH);
  localparam logic [CNT_WIDTH:0] FB_TARGET = (CNT_WIDTH + 1)'(FRAME_BEATS);
  localparam logic               LEN_CHK   = (FRAME_BEATS != 0);
  localparam logic               ONE_BAD   = (FRAME_BEATS != 0) && (FRAME_BEATS != 1);

  frame_state_e         r_state;
  frame_state_e         w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic [CNT_WIDTH:0]   w_cnt_plus;
  logic                 r_snk_ready;
  logic                 r_frame_err;
  logic [15:0]          r_err_count;
  logic                 w_accept;
  logic                 w_pop;
  logic                 w_write;
  logic                 w_err;
  logic [LVL_W-1:0]     w_level;
  logic [LVL_W-1:0]     w_level_nxt;
  logic [DW-1:0]        w_rd_data;

  assign w_accept   = bus.snk_valid & r_snk_ready;
  assign w_pop      = bus.out_valid & bus.out_ready;
  assign w_cnt_plus = {1'b0, r_cnt} + (CNT_WIDTH + 1)'(1);

  avalon_st_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_mem (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_write),
    .i_wr_data ({bus.snk_sop, bus.snk_eop, bus.snk_data}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_data),
    .o_level   (w_level)
  );

  // Ready is registered off the next level so it is low throughout reset and never sees out_ready.
  assign w_level_nxt = w_level + LVL_W'(w_write) - LVL_W'(w_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_snk_ready <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_snk_ready <= (w_level_nxt != FULL_LVL);
      r_frame_err <= w_err;
      if (w_err) r_err_count <= sat_inc16(r_err_count);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_SEEK;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      case (r_state)
        ST_SEEK:  if (bus.snk_sop && !bus.snk_eop) w_state_nxt = ST_FRAME;
        ST_FRAME: if (bus.snk_eop)                 w_state_nxt = ST_SEEK;
        default:                                   w_state_nxt = ST_SEEK;
      endcase
    end
  end

  // Beats outside a frame without SOP are consumed but never written.
  always_comb begin
    w_write   = 1'b0;
    w_err     = 1'b0;
    w_cnt_nxt = r_cnt;
    if (w_accept) begin
      case (r_state)
        ST_SEEK: begin
          if (bus.snk_sop) begin
            w_write = 1'b1;
            if (bus.snk_eop) w_err     = ONE_BAD;
            else             w_cnt_nxt = CNT_WIDTH'(1);
          end
        end
        ST_FRAME: begin
          w_write = 1'b1;
          if (bus.snk_sop) begin
            w_err     = 1'b1;
            w_cnt_nxt = CNT_WIDTH'(1);
          end else if (bus.snk_eop) begin
            w_err = LEN_CHK && (w_cnt_plus != FB_TARGET);
          end else if (r_cnt != '1) begin
            w_cnt_nxt = w_cnt_plus[CNT_WIDTH-1:0];
          end
        end
        default: w_write = 1'b0;
      endcase
    end
  end

  assign bus.snk_ready = r_snk_ready;
  assign bus.out_valid = (w_level != '0);
  assign bus.out_sop   = w_rd_data[DW-1];
  assign bus.out_eop   = w_rd_data[DW-2];
  assign bus.out_data  = w_rd_data[DATA_WIDTH-1:0];
  assign level         = w_level;
  assign frame_err     = r_frame_err;
  assign err_count     = r_err_count;
endmodule

// File: tb/tb_avalon_st_sink_fifo.sv
// tb/tb_avalon_st_sink_fifo.sv - self-checking bench for avalon_st_sink_fifo against a queue model
module tb_avalon_st_sink_fifo;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int FB    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  level;
  logic        frame_err;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  avalon_st_sink_fifo_if #(.DATA_WIDTH(DW)) bus();

  avalon_st_sink_fifo #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .FRAME_BEATS (FB),
    .CNT_WIDTH   (20)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .level     (level),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  logic [17:0] q[$];
  bit          in_frame;
  int          cnt;
  bit          err_exp;
  int          errs_exp;
  int          dut_pops;
  int          dut_errs;
  int          n_tests;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [17:0] h;
    chk("level", 32'(level), 32'(q.size()));
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    chk("snk_ready", 32'(bus.snk_ready), 32'(q.size() != DEPTH));
    chk("frame_err", 32'(frame_err), 32'(err_exp));
    chk("err_count", 32'(err_count), 32'(errs_exp));
    if (q.size() != 0) begin
      h = q[0];
      chk("out_data", 32'(bus.out_data), 32'(h[15:0]));
      chk("out_sop", 32'(bus.out_sop), 32'(h[17]));
      chk("out_eop", 32'(bus.out_eop), 32'(h[16]));
    end
    if (frame_err) dut_errs++;
  endtask

  // One cycle: check at the negedge, drive, advance the model, wait for the next negedge.
  task automatic step(input bit v, input bit s, input bit e, input logic [15:0] d, input bit ordy);
    bit acc, pop, err;
    check_outputs();
    if (bus.out_valid && ordy) dut_pops++;
    bus.snk_valid = v;
    bus.snk_sop   = s;
    bus.snk_eop   = e;
    bus.snk_data  = d;
    bus.out_ready = ordy;
    acc = v && (q.size() != DEPTH);
    pop = (q.size() != 0) && ordy;
    err = 1'b0;
    if (pop) void'(q.pop_front());
    if (acc) begin
      if (!in_frame) begin
        if (s) begin
          q.push_back({s, e, d});
          if (e) err = (FB != 0) && (FB != 1);
          else begin in_frame = 1'b1; cnt = 1; end
        end
      end else begin
        q.push_back({s, e, d});
        if (s) begin
          err = 1'b1;
          cnt = 1;
          if (e) in_frame = 1'b0;
        end else if (e) begin
          err = (FB != 0) && (cnt + 1 != FB);
          in_frame = 1'b0;
        end else cnt++;
      end
    end
    err_exp = err;
    if (err && errs_exp < 65535) errs_exp++;
    @(negedge clk);
  endtask

  task automatic send_beat(input bit s, input bit e, input logic [15:0] d, input bit ordy);
    bit acc;
    for (int t = 0; t < 20; t++) begin
      acc = (q.size() != DEPTH);
      step(1'b1, s, e, d, ordy);
      if (acc) return;
    end
    chk("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    for (int t = 0; t < 20 && q.size() != 0; t++) step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
  endtask

  task automatic do_reset();
    bus.snk_valid = 1'b0;
    bus.snk_sop   = 1'b0;
    bus.snk_eop   = 1'b0;
    bus.snk_data  = '0;
    bus.out_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_snk_ready", 32'(bus.snk_ready), 32'd0);
    chk("rst_out_data", 32'({bus.out_sop, bus.out_eop, bus.out_data}), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    q.delete();
    in_frame = 1'b0;
    cnt      = 0;
    err_exp  = 1'b0;
    errs_exp = 0;
    dut_pops = 0;
    dut_errs = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.snk_ready), 32'd1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset mid-stream with three beats buffered; first beat after release lacks SOP and is dropped.
    step(1'b1, 1'b1, 1'b0, 16'h1111, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h2222, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h3333, 1'b0);
    chk("mid_level", 32'(level), 32'd3);
    do_reset();
    step(1'b1, 1'b0, 1'b0, 16'h4444, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("seek_discard", 32'(level), 32'd0);

    // Junk then a correct 4-beat frame.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 16'hD000, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'hD001, 1'b1);
    step(1'b1, 1'b1, 1'b0, 16'hA000, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'hA001, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'hA002, 1'b1);
    step(1'b1, 1'b0, 1'b1, 16'hA003, 1'b1);
    drain();
    chk("junk_pops", 32'(dut_pops), 32'd4);
    chk("junk_errs", 32'(dut_errs), 32'd0);

    // Backpressure: fill with out_ready low, then release.
    do_reset();
    send_beat(1'b1, 1'b0, 16'hB000, 1'b0);
    for (int i = 1; i < 4; i++) send_beat(1'b0, 1'b0, 16'(16'hB000 + i), 1'b0);
    chk("bp_ready_low", 32'(bus.snk_ready), 32'd0);
    chk("bp_level_full", 32'(level), 32'd4);
    send_beat(1'b0, 1'b0, 16'hB004, 1'b1);
    send_beat(1'b0, 1'b1, 16'hB005, 1'b1);
    drain();
    chk("bp_pops", 32'(dut_pops), 32'd6);

    // Short frame: length error at EOP.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 16'hC000, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'hC001, 1'b1);
    step(1'b1, 1'b0, 1'b1, 16'hC002, 1'b1);
    chk("len_pulse", 32'(frame_err), 32'd1);
    drain();
    chk("len_errcnt", 32'(err_count), 32'd1);
    chk("len_pops", 32'(dut_pops), 32'd3);

    // Premature SOP restarts the frame count; the closing EOP is then correct.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 16'hE000, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'hE001, 1'b1);
    step(1'b1, 1'b1, 1'b0, 16'hE002, 1'b1);
    chk("pre_pulse", 32'(frame_err), 32'd1);
    step(1'b1, 1'b0, 1'b0, 16'hE003, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'hE004, 1'b1);
    step(1'b1, 1'b0, 1'b1, 16'hE005, 1'b1);
    drain();
    chk("pre_errcnt", 32'(err_count), 32'd1);
    chk("pre_pops", 32'(dut_pops), 32'd6);

    // Sustained throughput with out_ready held high.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, (i % 4) == 0, (i % 4) == 3, 16'($urandom), 1'b1);
      chk("tp_ready", 32'(bus.snk_ready), 32'd1);
      chk("tp_level_le1", 32'(level <= 3'd1), 32'd1);
    end
    drain();

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
           16'($urandom), ($urandom % 3) != 0);
    end
    drain();

    // Error counter saturation: every single-beat frame is a length error.
    do_reset();
    for (int i = 0; i < 65540; i++) step(1'b1, 1'b1, 1'b1, 16'($urandom), 1'b1);
    drain();
    chk("sat_errcnt", 32'(err_count), 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
